// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - symbol codes, encoder states and the Morse lookup function
package morse_pkg;

    // Digits '0'-'9'
    localparam logic [5:0] SYM_0 = 6'd0;
    localparam logic [5:0] SYM_1 = 6'd1;
    localparam logic [5:0] SYM_2 = 6'd2;
    localparam logic [5:0] SYM_3 = 6'd3;
    localparam logic [5:0] SYM_4 = 6'd4;
    localparam logic [5:0] SYM_5 = 6'd5;
    localparam logic [5:0] SYM_6 = 6'd6;
    localparam logic [5:0] SYM_7 = 6'd7;
    localparam logic [5:0] SYM_8 = 6'd8;
    localparam logic [5:0] SYM_9 = 6'd9;
    // Letters 'A'-'Z'
    localparam logic [5:0] SYM_A = 6'd10;
    localparam logic [5:0] SYM_B = 6'd11;
    localparam logic [5:0] SYM_C = 6'd12;
    localparam logic [5:0] SYM_D = 6'd13;
    localparam logic [5:0] SYM_E = 6'd14;
    localparam logic [5:0] SYM_F = 6'd15;
    localparam logic [5:0] SYM_G = 6'd16;
    localparam logic [5:0] SYM_H = 6'd17;
    localparam logic [5:0] SYM_I = 6'd18;
    localparam logic [5:0] SYM_J = 6'd19;
    localparam logic [5:0] SYM_K = 6'd20;
    localparam logic [5:0] SYM_L = 6'd21;
    localparam logic [5:0] SYM_M = 6'd22;
    localparam logic [5:0] SYM_N = 6'd23;
    localparam logic [5:0] SYM_O = 6'd24;
    localparam logic [5:0] SYM_P = 6'd25;
    localparam logic [5:0] SYM_Q = 6'd26;
    localparam logic [5:0] SYM_R = 6'd27;
    localparam logic [5:0] SYM_S = 6'd28;
    localparam logic [5:0] SYM_T = 6'd29;
    localparam logic [5:0] SYM_U = 6'd30;
    localparam logic [5:0] SYM_V = 6'd31;
    localparam logic [5:0] SYM_W = 6'd32;
    localparam logic [5:0] SYM_X = 6'd33;
    localparam logic [5:0] SYM_Y = 6'd34;
    localparam logic [5:0] SYM_Z = 6'd35;

    localparam logic [5:0] SYM_MAX = 6'd35;

    // Encoder state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MARK  = 3'd1;
    localparam logic [2:0] ST_SPACE = 3'd2;
    localparam logic [2:0] ST_CGAP  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        STATE_IDLE  = ST_IDLE,
        STATE_MARK  = ST_MARK,
        STATE_SPACE = ST_SPACE,
        STATE_CGAP  = ST_CGAP,
        STATE_ERR   = ST_ERR
    } morse_state_e;

    // Returns {len[2:0], pat[4:0]}; pat is MSB-first, left-aligned, 1 = dash.
    // Unused trailing pattern bits are zero; illegal codes return all zero.
    function automatic logic [7:0] morse_lookup(input logic [5:0] code);
        logic [7:0] r;
        r = 8'd0;
        case (code)
            SYM_0: r = {3'd5, 5'b11111};
            SYM_1: r = {3'd5, 5'b01111};
            SYM_2: r = {3'd5, 5'b00111};
            SYM_3: r = {3'd5, 5'b00011};
            SYM_4: r = {3'd5, 5'b00001};
            SYM_5: r = {3'd5, 5'b00000};
            SYM_6: r = {3'd5, 5'b10000};
            SYM_7: r = {3'd5, 5'b11000};
            SYM_8: r = {3'd5, 5'b11100};
            SYM_9: r = {3'd5, 5'b11110};
            SYM_A: r = {3'd2, 5'b01000};
            SYM_B: r = {3'd4, 5'b10000};
            SYM_C: r = {3'd4, 5'b10100};
            SYM_D: r = {3'd3, 5'b10000};
            SYM_E: r = {3'd1, 5'b00000};
            SYM_F: r = {3'd4, 5'b00100};
            SYM_G: r = {3'd3, 5'b11000};
            SYM_H: r = {3'd4, 5'b00000};
            SYM_I: r = {3'd2, 5'b00000};
            SYM_J: r = {3'd4, 5'b01110};
            SYM_K: r = {3'd3, 5'b10100};
            SYM_L: r = {3'd4, 5'b01000};
            SYM_M: r = {3'd2, 5'b11000};
            SYM_N: r = {3'd2, 5'b10000};
            SYM_O: r = {3'd3, 5'b11100};
            SYM_P: r = {3'd4, 5'b01100};
            SYM_Q: r = {3'd4, 5'b11010};
            SYM_R: r = {3'd3, 5'b01000};
            SYM_S: r = {3'd3, 5'b00000};
            SYM_T: r = {3'd1, 5'b10000};
            SYM_U: r = {3'd3, 5'b00100};
            SYM_V: r = {3'd4, 5'b00010};
            SYM_W: r = {3'd3, 5'b01100};
            SYM_X: r = {3'd4, 5'b10010};
            SYM_Y: r = {3'd4, 5'b10110};
            SYM_Z: r = {3'd4, 5'b11000};
            default: r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational symbol code to Morse length/pattern table
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] code,
    output logic       code_ok,
    output logic [2:0] len,
    output logic [4:0] pat
);

    logic [7:0] entry;

    // Table lookup plus legality flag; codes above SYM_MAX are rejected
    always_comb begin
        entry   = morse_lookup(code);
        code_ok = (code <= SYM_MAX);
        len     = entry[7:5];
        pat     = entry[4:0];
    end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - on/off key Morse encoder; optional MORSE_LOOPBACK_EN adds dot/dash pulses
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sym,
    input  logic       valid,
    output logic       ready,
    output logic       key,
    output logic       err
`ifdef MORSE_LOOPBACK_EN
    ,
    output logic       dot,
    output logic       dash
`endif
);

    localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [TW-1:0] T_DOT  = TW'(UNIT_CYCLES);
    localparam logic [TW-1:0] T_DASH = TW'(3 * UNIT_CYCLES);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    morse_state_e  state;
    logic [TW-1:0] timer;
    logic [2:0]    remaining;
    logic [4:0]    shift;

    logic          rom_ok;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;

    morse_rom u_rom (
        .code    (sym),
        .code_ok (rom_ok),
        .len     (rom_len),
        .pat     (rom_pat)
    );

    // Timers are loaded with the full state duration and expire at 1,
    // so every state lasts exactly its loaded number of cycles.
    wire expire = (timer == T_ONE);

    // Main sequencer: handshake, element timing and pattern shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            timer     <= '0;
            remaining <= '0;
            shift     <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (valid) begin
                        if (rom_ok) begin
                            state     <= STATE_MARK;
                            shift     <= rom_pat;
                            remaining <= rom_len;
                            timer     <= rom_pat[4] ? T_DASH : T_DOT;
                        end else begin
                            state <= STATE_ERR;
                        end
                    end
                end
                STATE_MARK: begin
                    if (expire) begin
                        if (remaining > 3'd1) begin
                            state <= STATE_SPACE;
                            timer <= T_DOT;
                        end else begin
                            state <= STATE_CGAP;
                            timer <= T_DASH;
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                STATE_SPACE: begin
                    if (expire) begin
                        state     <= STATE_MARK;
                        shift     <= {shift[3:0], 1'b0};
                        remaining <= remaining - 3'd1;
                        timer     <= shift[3] ? T_DASH : T_DOT;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                STATE_CGAP: begin
                    if (expire) begin
                        state <= STATE_IDLE;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                STATE_ERR: begin
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign ready = (state == STATE_IDLE);
    assign key   = (state == STATE_MARK);
    assign err   = (state == STATE_ERR);

`ifdef MORSE_LOOPBACK_EN
    logic mark_first;

    // Flags the first cycle of each mark element for the loopback pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_first <= 1'b0;
        end else begin
            mark_first <= ((state == STATE_IDLE) && valid && rom_ok) ||
                          ((state == STATE_SPACE) && expire);
        end
    end

    assign dot  = key && mark_first && !shift[4];
    assign dash = key && mark_first &&  shift[4];
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - randomized self-checking bench for morse_encoder against a timing model
module tb_morse_encoder;

    localparam int U = 2;

    logic       clk;
    logic       rst_n;
    logic [5:0] sym;
    logic       valid;
    logic       ready;
    logic       key;
    logic       err;
`ifdef MORSE_LOOPBACK_EN
    logic       dot;
    logic       dash;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_dot  = 0;
    int cnt_dash = 0;

    bit exp_key[$];
    bit exp_dot[$];
    bit exp_dash[$];

    string mtab[36] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sym   (sym),
        .valid (valid),
        .ready (ready),
        .key   (key),
        .err   (err)
`ifdef MORSE_LOOPBACK_EN
        ,
        .dot   (dot),
        .dash  (dash)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Key waveform after the transfer edge, straight from the Morse timing rules
    function automatic void build_expect(input int code);
        string s;
        s = mtab[code];
        exp_key.delete();
        exp_dot.delete();
        exp_dash.delete();
        for (int e = 0; e < s.len(); e++) begin
            int w;
            w = (s[e] == "-") ? 3 * U : U;
            for (int c = 0; c < w; c++) begin
                exp_key.push_back(1'b1);
                exp_dot.push_back((c == 0) && (s[e] == "."));
                exp_dash.push_back((c == 0) && (s[e] == "-"));
            end
            if (e != s.len() - 1) begin
                for (int c = 0; c < U; c++) begin
                    exp_key.push_back(1'b0);
                    exp_dot.push_back(1'b0);
                    exp_dash.push_back(1'b0);
                end
            end
        end
        for (int c = 0; c < 3 * U; c++) begin
            exp_key.push_back(1'b0);
            exp_dot.push_back(1'b0);
            exp_dash.push_back(1'b0);
        end
    endfunction

    // Called at a negedge while idle; returns at the negedge where ready is back
    task automatic run_char(input int code, input int next_code, output int busy);
        int idx;
        build_expect(code);
        chk("ready_before", int'(ready), 1);
        sym   = 6'(code);
        valid = 1'b1;
        @(posedge clk);
        busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (next_code >= 0) sym = 6'(next_code);
                else valid = 1'b0;
            end
            chk("err_quiet", int'(err), 0);
            if (ready) begin
                chk("key_at_ready", int'(key), 0);
                break;
            end
            idx = busy;
            busy++;
            chk("key", int'(key), (idx < exp_key.size()) ? int'(exp_key[idx]) : 0);
`ifdef MORSE_LOOPBACK_EN
            chk("dot", int'(dot), (idx < exp_dot.size()) ? int'(exp_dot[idx]) : 0);
            chk("dash", int'(dash), (idx < exp_dash.size()) ? int'(exp_dash[idx]) : 0);
            chk("dot_dash_excl", int'(dot & dash), 0);
            cnt_dot  += int'(dot);
            cnt_dash += int'(dash);
`endif
        end
        chk("busy_cycles", busy, exp_key.size());
    endtask

    task automatic run_invalid(input int code);
        chk("ready_before_inv", int'(ready), 1);
        sym   = 6'(code);
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("inv_err", int'(err), 1);
        chk("inv_key", int'(key), 0);
        chk("inv_ready_busy", int'(ready), 0);
        @(negedge clk);
        chk("inv_err_drop", int'(err), 0);
        chk("inv_ready_back", int'(ready), 1);
        chk("inv_key_after", int'(key), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_key", int'(key), 0);
            chk("idle_ready", int'(ready), 1);
            chk("idle_err", int'(err), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int code;
        rst_n = 1'b0;
        valid = 1'b0;
        sym   = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_key", int'(key), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);

        // E: one dot, 8 busy cycles
        run_char(14, -1, busy);
        chk("E_busy", busy, 8);
        idle_cycles(2);

        // Q: --.- , 32 busy cycles
        run_char(26, -1, busy);
        chk("Q_busy", busy, 32);
        idle_cycles(1);

        // '0': five dashes, 44 busy cycles
        cnt_dot  = 0;
        cnt_dash = 0;
        run_char(0, -1, busy);
        chk("zero_busy", busy, 44);
`ifdef MORSE_LOOPBACK_EN
        chk("zero_dash_pulses", cnt_dash, 5);
        chk("zero_dot_pulses", cnt_dot, 0);
`endif
        idle_cycles(1);

        // Illegal code
        run_invalid(40);
        idle_cycles(1);

        // A then N with valid held: second transfer on the first ready cycle
        run_char(10, 23, busy);
        chk("A_busy", busy, 16);
        run_char(23, -1, busy);
        chk("N_busy", busy, 16);
        idle_cycles(1);

        // Reset in the 2nd cycle of T's dash
        chk("T_ready", int'(ready), 1);
        sym   = 6'd29;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("T_key_c1", int'(key), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("T_rst_key_async", int'(key), 0);
        @(negedge clk);
        chk("T_rst_key_held", int'(key), 0);
        rst_n = 1'b1;
        idle_cycles(10);

        // Randomized characters, illegal codes and idle gaps
        for (int n = 0; n < 40; n++) begin
            code = int'($urandom_range(0, 63));
            if (code > 35) run_invalid(code);
            else run_char(code, -1, busy);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
Transmit-side counterpart of the team's Morse decoder. It accepts one 6-bit symbol code per handshake and plays it out as an on/off key waveform with standard Morse timing. Dot = 1 unit, dash = 3 units, intra-character gap = 1 unit, inter-character gap = 3 units. It sits between a character source (UART/FIFO/test driver) and the key/tone output; with loopback enabled it drives the decoder's dot/dash inputs directly.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit (>=1)

Ports:
Clock  input  1  system clock, all state on posedge
Reset  input  1  asynchronous, active-low reset
sym  input  6  symbol code: 0-9 = digits '0'-'9', 10-35 = 'A'-'Z' in order, 36-63 invalid
valid  input  1  sym is presented
ready  output  1  encoder idle, will accept on this cycle
key  output  1  Morse key: 1 = tone on (mark), 0 = off (space)
err  output  1  one-cycle pulse: an invalid code was accepted and dropped

Behaviour:
- Reset (Reset=0, async): state IDLE, key=0, err=0, counters cleared. ready=1 once reset is released. Reset mid-character aborts immediately: key drops to 0 asynchronously, and no partial character resumes.
- Handshake: transfer occurs on a posedge with valid=1 and ready=1. ready is 1 only in IDLE, as a combinational decode of state. sym is sampled only at transfer and may change afterwards. valid with ready=0 is ignored and not queued.
- Lookup: code -> {len[2:0] in 1..5, pat[4:0]}. Pattern is MSB-first, left-aligned, 1 = dash. Example: A=.- gives len 2, pat 01xxx. Digits are 5 elements; letters are 1-4.
- States and transitions:
  - IDLE -> MARK on a valid transfer with a legal code. Load the shift register, set elements-remaining = len, and load the timer with U or 3U from pat[4].
  - IDLE -> ERR on transfer of an illegal code.
  - MARK: key=1 and the timer counts down.
    - At expiry with elements-remaining > 1: go to SPACE with timer = U.
    - At expiry on the last element: go to CGAP with timer = 3U.
  - SPACE: key=0. At expiry, shift the pattern, decrement the count, and return to MARK with a new timer (U or 3U).
  - CGAP: key=0. At expiry go to IDLE.
  - ERR: err=1 and key=0 for exactly 1 cycle, then IDLE.
- Latency: key rises in the first cycle after the transfer edge.
- Character occupancy: sum(marks) + (len-1)*U + 3U cycles. ready returns 1 in the following cycle. Every state has an exact duration; there are no off-by-one extra cycles.
- Back-to-back characters: if valid is held, the next symbol transfers on the first ready cycle. The result is one idle cycle beyond the 3U gap, which is accepted.
- Timer width: $clog2(3*UNIT_CYCLES+1). Element counter: 3 bits. No overflow is possible for legal parameters.
- Word spaces are outside this block's scope; the source inserts idle time itself.

Optional Feature:
MORSE_LOOPBACK_EN
- Defined: adds outputs dot and dash (1 bit each). Each pulses high for exactly one cycle, the first cycle of each MARK element; dot is pulsed for a dot element, dash for a dash element. The two are never high together. This lets the encoder feed the decoder bit-exactly.
- Undefined: the ports are absent and the block is key-only.
- Timing of key, ready and err is identical in both builds.

Decomposition:
- Package morse_pkg:
  - 6-bit symbol code constants (digits 0-9, letters A-Z)
  - SYM_MAX = 35
  - typedef for the encoder state enum
  - function morse_lookup(code) returning {len, pat}
- Sub-module morse_rom: purely combinational, code -> {valid_code, len, pat}. It is shared with future tooling and testbench reference models.
- The encoder FSM, timer and shifter live in morse_encoder.

Test Plan:
All scenarios use UNIT_CYCLES=2.
- E (code 14) transferred at cycle 0 -> key=1 on cycles 1-2, key=0 on cycles 3-8; ready=0 on cycles 1-8 and ready=1 on cycle 9.
- Q (code 26, --.-) -> key high runs of 6, 6, 2, 6 cycles separated by 2-cycle spaces, then a 6-cycle gap; total 32 cycles busy.
- '0' (code 0, -----) -> five 6-cycle marks, four 2-cycle spaces, then a 6-cycle gap = 44 busy cycles; with MORSE_LOOPBACK_EN, exactly 5 dash pulses and 0 dot pulses.
- Invalid code 40 -> err=1 for one cycle, key stays 0, ready=1 again two cycles after the transfer.
- valid held high with sym=A then sym=N (codes 10, 23) -> second transfer on the first ready cycle; waveforms .- then -. with a 6-cycle gap plus 1 idle cycle between them.
- Reset asserted in the 2nd cycle of a dash in T (code 29) -> key=0 immediately; after release ready=1 and key stays 0 until a new transfer.
